// File: rtl/vdp18_pkg.sv
// Shared vdp18 types: VRAM access slot kinds and CPU scheduler types.
package vdp18_pkg;

  typedef enum logic [3:0] {
    AC_NONE,
    AC_PNT,
    AC_PGT,
    AC_PCT,
    AC_STST,
    AC_SATY,
    AC_SATX,
    AC_SATN,
    AC_SATC,
    AC_SPTH,
    AC_SPTL,
    AC_CPU
  } access_t;

  typedef enum logic [1:0] {
    NONE,
    RD,
    WR
  } cpu_req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SLOT,
    ACCESS
  } cpu_sched_state_t;

endpackage

// File: rtl/vdp18_cpu_vram_sched.sv
// CPU-side VRAM access scheduler: holds one pending read-ahead/write, waits for
// an AC_CPU slot, performs the access for one slot and advances the pointer.
module vdp18_cpu_vram_sched
  import vdp18_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clk_en_acc_i,
  input  access_t           access_type_i,
  input  logic              addr_load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              addr_rd_i,
  input  logic              wr_req_i,
  input  logic [7:0]        wdata_i,
  input  logic              rd_ack_i,
  input  logic [7:0]        vram_d_i,
  output logic              cpu_slot_o,
  output logic [ADDR_W-1:0] vram_a_o,
  output logic              vram_we_o,
  output logic [7:0]        vram_d_o,
  output logic [7:0]        rdata_o,
  output logic              busy_o,
  output logic              overrun_o
);

  cpu_sched_state_t  r_state, w_state_nxt;
  cpu_req_t          r_kind, w_kind_nxt;
  logic [7:0]        r_wdata, w_wdata_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [7:0]        r_rdata, w_rdata_nxt;
  logic              r_cpu_slot, r_vram_we, r_overrun;
  logic [7:0]        r_vram_d;
  logic              w_req, w_cpu_slot_now, w_overrun, w_we_nxt;

  assign w_req          = addr_load_i | wr_req_i | rd_ack_i;
  assign w_cpu_slot_now = clk_en_acc_i && (access_type_i == AC_CPU);

  always_comb begin
    w_state_nxt = r_state;
    w_kind_nxt  = r_kind;
    w_wdata_nxt = r_wdata;
    w_ptr_nxt   = r_ptr;
    w_rdata_nxt = r_rdata;
    w_overrun   = 1'b0;
    case (r_state)
      IDLE, WAIT_SLOT: begin
        // A request in WAIT_SLOT replaces the pending one; a bare load cancels it
        if (w_req) begin
          if (addr_load_i) w_ptr_nxt = addr_i;
          if (wr_req_i) begin
            w_kind_nxt  = WR;
            w_wdata_nxt = wdata_i;
          end else if (addr_load_i) begin
            w_kind_nxt = addr_rd_i ? RD : NONE;
          end else begin
            w_kind_nxt = RD;
          end
          if (r_state == WAIT_SLOT) w_overrun = 1'b1;
        end
        if (w_kind_nxt == NONE)
          w_state_nxt = IDLE;
        else if ((r_state == WAIT_SLOT) && w_cpu_slot_now)
          w_state_nxt = ACCESS;
        else
          w_state_nxt = WAIT_SLOT;
      end
      ACCESS: begin
        if (w_req) w_overrun = 1'b1;
        if (clk_en_acc_i) begin
          if (r_kind == RD) w_rdata_nxt = vram_d_i;
          w_ptr_nxt   = r_ptr + ADDR_W'(1);
          w_kind_nxt  = NONE;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_kind_nxt  = NONE;
      end
    endcase
  end

  assign w_we_nxt = (w_state_nxt == ACCESS) && (w_kind_nxt == WR);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_kind     <= NONE;
      r_wdata    <= 8'h00;
      r_ptr      <= '0;
      r_rdata    <= 8'h00;
      r_cpu_slot <= 1'b0;
      r_vram_we  <= 1'b0;
      r_vram_d   <= 8'h00;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_kind     <= w_kind_nxt;
      r_wdata    <= w_wdata_nxt;
      r_ptr      <= w_ptr_nxt;
      r_rdata    <= w_rdata_nxt;
      r_cpu_slot <= (w_state_nxt == ACCESS);
      r_vram_we  <= w_we_nxt;
      r_vram_d   <= w_we_nxt ? w_wdata_nxt : 8'h00;
      r_overrun  <= w_overrun;
    end
  end

  assign cpu_slot_o = r_cpu_slot;
  assign vram_a_o   = r_ptr;
  assign vram_we_o  = r_vram_we;
  assign vram_d_o   = r_vram_d;
  assign rdata_o    = r_rdata;
  assign overrun_o  = r_overrun;
  assign busy_o     = (r_state != IDLE);

endmodule
